// File: rtl/gate_response_checker_if.sv
// Stimulus/response bus between the BIST checker and the two-input all_gates block.
// master = checker (drives a/b, reads gate outputs); slave = gate block.
interface gate_response_checker_if;
   logic a_o;
   logic b_o;
   logic and_i;
   logic or_i;
   logic xor_i;
   logic nand_i;
   logic nor_i;

   modport master (
      output a_o,
      output b_o,
      input  and_i,
      input  or_i,
      input  xor_i,
      input  nand_i,
      input  nor_i
   );

   modport slave (
      input  a_o,
      input  b_o,
      output and_i,
      output or_i,
      output xor_i,
      output nand_i,
      output nor_i
   );
endinterface

// File: rtl/gate_response_checker.sv
// BIST response checker for all_gates: walks the four a/b vectors, compares five gate outputs.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN ends the run at the first failing vector.
module gate_response_checker #(
   parameter int unsigned SETTLE = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   gate_response_checker_if.master    gate,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [2:0]                 err_count,
   output logic [3:0]                 fail_mask,
   output logic [4:0]                 gate_mask
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned VEC_W = 2;
   localparam int unsigned ERR_W = 3;
   localparam int unsigned NVEC  = 4;
   localparam int unsigned NGATE = 5;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NVEC - 1);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [VEC_W-1:0]   v;

   logic [NGATE-1:0]   exp_c;
   logic [NGATE-1:0]   got_c;
   logic [NGATE-1:0]   mm_c;
   logic               fail_c;
   logic               last_c;
   logic [ERR_W-1:0]   err_nxt_c;
   logic [VEC_W-1:0]   v_nxt_c;

   // Expected truth table for the vector currently driven, ordered {nor,nand,xor,or,and}.
   always_comb begin
      exp_c     = {~(v[1] | v[0]), ~(v[1] & v[0]), v[1] ^ v[0], v[1] | v[0], v[1] & v[0]};
      got_c     = {gate.nor_i, gate.nand_i, gate.xor_i, gate.or_i, gate.and_i};
      mm_c      = got_c ^ exp_c;
      fail_c    = |mm_c;
      err_nxt_c = err_count + ERR_W'(fail_c);
      v_nxt_c   = v + VEC_W'(1);
      last_c    = (v == VEC_LAST) || (STOP_ON_FAIL && fail_c);
   end

   // Run sequencer; a/b mirror v so the gate block always sees the vector being counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         v         <= '0;
         gate.a_o  <= 1'b0;
         gate.b_o  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_mask <= '0;
         gate_mask <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_DRIVE;
                  cnt       <= '0;
                  v         <= '0;
                  gate.a_o  <= 1'b0;
                  gate.b_o  <= 1'b0;
                  busy      <= 1'b1;
                  pass      <= 1'b0;
                  err_count <= '0;
                  fail_mask <= '0;
                  gate_mask <= '0;
               end
            end

            S_DRIVE: begin
               if (cnt == CNT_LAST) begin
                  state <= S_SAMPLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_SAMPLE: begin
               if (fail_c) begin
                  fail_mask[v] <= 1'b1;
               end
               gate_mask <= gate_mask | mm_c;
               err_count <= err_nxt_c;
               if (last_c) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt_c == '0);
               end else begin
                  state    <= S_DRIVE;
                  v        <= v_nxt_c;
                  gate.a_o <= v_nxt_c[1];
                  gate.b_o <= v_nxt_c[0];
               end
            end

            S_DONE: begin
               // start is deliberately ignored here; results stay put.
               state    <= S_IDLE;
               v        <= '0;
               gate.a_o <= 1'b0;
               gate.b_o <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (SETTLE=1 and SETTLE=3) against a time-based model
// with injectable stuck-at/invert faults on the emulated gate block.
module tb_gate_response_checker;

   localparam int unsigned SET0 = 1;
   localparam int unsigned SET1 = 3;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] s0m, s1m, invm;

   logic       busy_d [2];
   logic       done_d [2];
   logic       pass_d [2];
   logic [2:0] err_d  [2];
   logic [3:0] fm_d   [2];
   logic [4:0] gm_d   [2];

   gate_response_checker_if g0 ();
   gate_response_checker_if g1 ();

   always #5 clk = ~clk;

   // Truth table per vector index {a,b}, ordered {nor,nand,xor,or,and}.
   function automatic logic [4:0] golden(input logic [1:0] vv);
      case (vv)
         2'd0:    return 5'b11000;
         2'd1:    return 5'b01110;
         2'd2:    return 5'b01110;
         default: return 5'b00011;
      endcase
   endfunction

   function automatic logic [4:0] gate_out(input logic [1:0] vv, input logic [4:0] s0,
                                           input logic [4:0] s1, input logic [4:0] inv);
      return ((golden(vv) ^ inv) & ~s0) | s1;
   endfunction

   assign {g0.nor_i, g0.nand_i, g0.xor_i, g0.or_i, g0.and_i} = gate_out({g0.a_o, g0.b_o}, s0m, s1m, invm);
   assign {g1.nor_i, g1.nand_i, g1.xor_i, g1.or_i, g1.and_i} = gate_out({g1.a_o, g1.b_o}, s0m, s1m, invm);

   gate_response_checker #(.SETTLE(SET0)) u0 (
      .clk(clk), .rst(rst), .start(start), .gate(g0),
      .busy(busy_d[0]), .done(done_d[0]), .pass(pass_d[0]),
      .err_count(err_d[0]), .fail_mask(fm_d[0]), .gate_mask(gm_d[0])
   );

   gate_response_checker #(.SETTLE(SET1)) u1 (
      .clk(clk), .rst(rst), .start(start), .gate(g1),
      .busy(busy_d[1]), .done(done_d[1]), .pass(pass_d[1]),
      .err_count(err_d[1]), .fail_mask(fm_d[1]), .gate_mask(gm_d[1])
   );

   // Model: a run is just "t edges since acceptance"; vector j is compared when t reaches (j+1)*(S+1).
   int         cyc = 0;
   bit         m_run [2];
   int         m_t   [2];
   int         acc   [2];
   logic       m_a [2], m_b [2], m_busy [2], m_done [2], m_pass [2];
   logic [2:0] m_err [2];
   logic [3:0] m_fm  [2];
   logic [4:0] m_gm  [2];

   always @(posedge clk) begin
      int s;
      int j;
      logic [4:0] mm;
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         s = (i == 0) ? int'(SET0) : int'(SET1);
         if (rst) begin
            m_run[i] = 1'b0; m_t[i] = 0;
            m_a[i] = 1'b0; m_b[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
            m_err[i] = '0; m_fm[i] = '0; m_gm[i] = '0;
         end else if (!m_run[i]) begin
            if (m_done[i]) begin
               m_done[i] = 1'b0; m_a[i] = 1'b0; m_b[i] = 1'b0;
            end else if (start) begin
               m_run[i] = 1'b1; m_t[i] = 0; acc[i] = cyc;
               m_busy[i] = 1'b1; m_pass[i] = 1'b0; m_err[i] = '0; m_fm[i] = '0; m_gm[i] = '0;
               m_a[i] = 1'b0; m_b[i] = 1'b0;
            end
         end else begin
            m_t[i] = m_t[i] + 1;
            if (m_t[i] % (s + 1) == 0) begin
               j  = m_t[i] / (s + 1) - 1;
               mm = gate_out(2'(j), s0m, s1m, invm) ^ golden(2'(j));
               if (mm != 5'b0) begin
                  m_fm[i][j] = 1'b1;
                  m_gm[i]    = m_gm[i] | mm;
                  m_err[i]   = m_err[i] + 3'd1;
               end
               if (j == 3 || (STOP && mm != 5'b0)) begin
                  m_run[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b1; m_pass[i] = (m_err[i] == 3'd0);
               end else begin
                  m_a[i] = ((j + 1) / 2) % 2 == 1;
                  m_b[i] = (j + 1) % 2 == 1;
               end
            end
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   bit seen_done [2];
   int lat [2];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of both instances against the model, sampled on the falling edge.
   task automatic tick();
      logic [16:0] act, exp;
      logic a, b;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         a   = (i == 0) ? g0.a_o : g1.a_o;
         b   = (i == 0) ? g0.b_o : g1.b_o;
         act = {a, b, busy_d[i], done_d[i], pass_d[i], err_d[i], fm_d[i], gm_d[i]};
         exp = {m_a[i], m_b[i], m_busy[i], m_done[i], m_pass[i], m_err[i], m_fm[i], m_gm[i]};
         n_cmp++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle_dut%0d: got %b expected %b (a,b,busy,done,pass,err,fm,gm) t=%0t",
                     i, act, exp, $time);
         end
         if (done_d[i] === 1'b1) begin
            seen_done[i] = 1'b1;
            lat[i]       = cyc - acc[i];
         end
      end
   endtask

   task automatic start_run(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] inv);
      s0m = s0; s1m = s1; invm = inv;
      seen_done[0] = 1'b0; seen_done[1] = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!(seen_done[0] && seen_done[1] && !m_done[0] && !m_done[1]) && n < 100) begin
         tick();
         n++;
      end
      chk("run_completes", int'(seen_done[0] && seen_done[1]), 1);
   endtask

   task automatic chk_res(input int i, input string tag, input int p, input int e,
                          input int fm, input int gm);
      chk({tag, "_pass"}, int'(pass_d[i]), p);
      chk({tag, "_err"},  int'(err_d[i]),  e);
      chk({tag, "_fmask"}, int'(fm_d[i]),  fm);
      chk({tag, "_gmask"}, int'(gm_d[i]),  gm);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s0m = '0; s1m = '0; invm = '0;
      seen_done[0] = 1'b0; seen_done[1] = 1'b0; lat[0] = 0; lat[1] = 0;
      repeat (3) tick();
      chk("rst_busy", int'(busy_d[0]), 0);
      chk("rst_ab", int'({g1.a_o, g1.b_o}), 0);
      chk_res(1, "rst", 0, 0, 0, 0);
      rst = 1'b0;
      tick();

      // Golden block.
      start_run(5'b0, 5'b0, 5'b0);
      wait_done();
      chk("golden_lat_s1", lat[0], 8);
      chk("golden_lat_s3", lat[1], 16);
      chk_res(0, "golden", 1, 0, 0, 0);

      // and stuck at 0: only vector 3 fails.
      start_run(5'b00001, 5'b0, 5'b0);
      wait_done();
      chk_res(0, "and0", 0, 1, 4'b1000, 5'b00001);

      // xor inverted on every vector.
      start_run(5'b0, 5'b0, 5'b00100);
      wait_done();
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      chk_res(1, "xorinv", 0, 1, 4'b0001, 5'b00100);
`else
      chk("xorinv_lat_s3", lat[1], 16);
      chk_res(1, "xorinv", 0, 4, 4'b1111, 5'b00100);
`endif

      // Back-to-back: golden, then or stuck at 0; acceptance clears the old pass.
      start_run(5'b0, 5'b0, 5'b0);
      wait_done();
      chk("b2b_first_pass", int'(pass_d[0]), 1);
      start_run(5'b00010, 5'b0, 5'b0);
      chk("b2b_pass_cleared", int'(pass_d[0]), 0);
      wait_done();
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      chk_res(0, "or0", 0, 1, 4'b0010, 5'b00010);
`else
      chk_res(0, "or0", 0, 3, 4'b1110, 5'b00010);
`endif

      // Second start mid-run is ignored; reset at vector 2 discards the run.
      start_run(5'b0, 5'b0, 5'b0);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("midrun_vec2_ab", int'({g0.a_o, g0.b_o}), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      seen_done[0] = 1'b0; seen_done[1] = 1'b0;
      chk("midrst_busy", int'(busy_d[1]), 0);
      chk("midrst_ab", int'({g0.a_o, g0.b_o}), 0);
      chk_res(0, "midrst", 0, 0, 0, 0);
      repeat (20) tick();
      chk("midrst_no_done", int'(seen_done[0] || seen_done[1]), 0);
      start_run(5'b0, 5'b0, 5'b0);
      wait_done();
      chk_res(1, "after_rst", 1, 0, 0, 0);

      // Random phase: sparse faults, start spam, occasional reset.
      for (int c = 0; c < 1500; c++) begin
         if (c % 37 == 0) begin
            s0m  = 5'($urandom & $urandom & $urandom);
            s1m  = 5'($urandom & $urandom & $urandom);
            invm = 5'($urandom & $urandom & $urandom);
         end
         start = ($urandom_range(0, 3) == 0);
         rst   = ($urandom_range(0, 99) == 0);
         tick();
      end
      start = 1'b0; rst = 1'b0;
      repeat (40) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
